// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared arbiter state type, requester indices and Avalon byteenable constants
package mips_cpu_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} arb_state_t;
  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA = 1;
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_BYTE = 4'b0001;
endpackage

// File: rtl/mips_cpu_rr_pick.sv
// mips_cpu_rr_pick: 2-way round-robin picker; i_req requests, i_last previous winner, o_pick one-hot winner (tie goes to the one that did not win last)
module mips_cpu_rr_pick (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_pick
);
  always_comb o_pick = (&i_req) ? (i_last ? 2'b01 : 2'b10) : i_req;
endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// mips_cpu_bus_arbiter: shares one Avalon master between fetch (r0) and data (r1) slaves with locked round-robin grants, grant/bus_timeout/proto_err status
import mips_cpu_pkg::*;
module mips_cpu_bus_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] r0_address,
  input  logic        r0_read,
  input  logic        r0_write,
  input  logic [31:0] r0_writedata,
  input  logic [3:0]  r0_byteenable,
  output logic [31:0] r0_readdata,
  output logic        r0_waitrequest,
  input  logic [31:0] r1_address,
  input  logic        r1_read,
  input  logic        r1_write,
  input  logic [31:0] r1_writedata,
  input  logic [3:0]  r1_byteenable,
  output logic [31:0] r1_readdata,
  output logic        r1_waitrequest,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [1:0]  grant,
  output logic        bus_timeout,
  output logic        proto_err
);
  localparam int CW = $clog2(TIMEOUT + 2);
  arb_state_t r_state, w_next;
  logic          r_last, r_timeout, r_proto;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    w_req, w_pick;
  logic          w_g0, w_g1, w_rd, w_wr, w_stall;
  assign w_req = {r1_read | r1_write, r0_read | r0_write};
  assign w_g0 = r_state == GNT0;
  assign w_g1 = r_state == GNT1;
  mips_cpu_rr_pick u_pick (.i_req(w_req), .i_last(r_last), .o_pick(w_pick));
  always_comb begin
    w_rd = w_g0 ? r0_read : w_g1 & r1_read;
    w_wr = w_g0 ? r0_write : w_g1 & r1_write;
    address = w_g0 ? r0_address : w_g1 ? r1_address : '0;
    writedata = w_g0 ? r0_writedata : w_g1 ? r1_writedata : '0;
    byteenable = w_g0 ? r0_byteenable : w_g1 ? r1_byteenable : '0;
    write = w_wr;
    read = w_rd & ~w_wr;
    grant = {w_g1, w_g0};
    r0_waitrequest = ~(w_g0 & ~waitrequest);
    r1_waitrequest = ~(w_g1 & ~waitrequest);
    r0_readdata = readdata;
    r1_readdata = readdata;
    w_stall = (w_rd | w_wr) & waitrequest;
    w_cnt_nxt = w_stall ? ((r_cnt == CW'(TIMEOUT)) ? r_cnt : r_cnt + CW'(1)) : '0;
    w_next = (r_state == IDLE) ? (w_pick[REQ_FETCH] ? GNT0 : w_pick[REQ_DATA] ? GNT1 : IDLE)
           : w_stall ? r_state : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last <= 1'b1;
      r_cnt <= '0;
      r_timeout <= 1'b0;
      r_proto <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && |w_pick) r_last <= w_pick[REQ_DATA];
      r_cnt <= w_cnt_nxt;
      r_timeout <= r_timeout | ((TIMEOUT != 0) & w_stall & (w_cnt_nxt == CW'(TIMEOUT)));
      r_proto <= r_proto | (w_rd & w_wr);
    end
  end
  assign bus_timeout = r_timeout;
  assign proto_err = r_proto;
endmodule
